// File: rtl/dbus_ram.sv
// Single-port data-bus RAM with 1-cycle registered reads and lane writes.
// Optional DBUS_RAM_ERR_EN adds a registered, sticky access-error flag.
module dbus_ram #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dbus_addr_i,
  input  logic        dbus_rd_i,
  input  logic        dbus_we_i,
  input  logic [2:0]  dbus_size_i,
  input  logic [31:0] dbus_data_i,
  output logic [31:0] dbus_data_o,
  output logic        dbus_rvld_o,
  output logic        dbus_err_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned HI = DEPTH_LOG2 + 2;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  logic [31:0] mem [DEPTH];

  state_e                state_q;
  state_e                state_d;
  logic [31:0]           data_q;
  logic                  hit;
  logic                  size_ok;
  logic                  misal;
  logic                  rd_ok;
  logic                  wr_ok;
  logic [3:0]            be;
  logic [DEPTH_LOG2-1:0] idx;

  assign hit = dbus_addr_i[31:HI] == BASE_ADDR[31:HI];
  assign idx = dbus_addr_i[HI-1:2];

  assign size_ok = (dbus_size_i == 3'b001) ||
                   (dbus_size_i == 3'b010) ||
                   (dbus_size_i == 3'b100);

`ifdef DBUS_RAM_ERR_EN
  assign misal = (dbus_size_i[1] & dbus_addr_i[0]) |
                 (dbus_size_i[2] & (|dbus_addr_i[1:0]));
`else
  assign misal = 1'b0;
`endif

  assign rd_ok = dbus_rd_i & ~dbus_we_i & size_ok & hit & ~misal;
  assign wr_ok = dbus_we_i & ~dbus_rd_i & size_ok & hit & ~misal;

  // Halfword lanes ignore addr[0], word lanes ignore addr[1:0].
  always_comb begin
    be = 4'b0000;
    if (size_ok) begin
      unique case (1'b1)
        dbus_size_i[0]: be = 4'b0001 << dbus_addr_i[1:0];
        dbus_size_i[1]: be = dbus_addr_i[1] ? 4'b1100 : 4'b0011;
        dbus_size_i[2]: be = 4'b1111;
        default:        be = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= dbus_data_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = rd_ok ? RESP : IDLE;
      RESP:    state_d = rd_ok ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (rd_ok) data_q <= mem[idx];
    end
  end

  assign dbus_data_o = data_q;
  assign dbus_rvld_o = state_q == RESP;

`ifdef DBUS_RAM_ERR_EN
  logic req;
  logic bad;
  logic err_q;

  assign req = dbus_rd_i | dbus_we_i;
  assign bad = req & ~(rd_ok | wr_ok);

  // Sticky: only a new request may change the flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if (req) begin
      err_q <= bad;
    end
  end

  assign dbus_err_o = err_q;
`else
  assign dbus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_ram.sv
// Scoreboard bench for dbus_ram: directed requests push expected reads,
// a negedge monitor pops and compares data and arrival cycle.
module tb_dbus_ram;

`ifdef DBUS_RAM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  localparam logic [2:0] SB = 3'b001;
  localparam logic [2:0] SH = 3'b010;
  localparam logic [2:0] SW = 3'b100;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        rd = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  size = 3'b000;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvld;
  logic        err;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  dbus_ram dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .dbus_addr_i (addr),
    .dbus_rd_i   (rd),
    .dbus_we_i   (we),
    .dbus_size_i (size),
    .dbus_data_i (wdata),
    .dbus_data_o (rdata),
    .dbus_rvld_o (rvld),
    .dbus_err_o  (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic r, input logic w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rd    = r;
    we    = w;
    size  = s;
    addr  = a;
    wdata = d;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [2:0] s, input logic [31:0] a,
                    input logic [31:0] d);
    issue(1'b0, 1'b1, s, a, d);
  endtask

  // Expected data arrives at the negedge after the sampling edge.
  task automatic rd_exp(input logic [31:0] a, input logic [31:0] e);
    issue(1'b1, 1'b0, SW, a, 32'h0);
    sb.push_back('{cyc: cyc + 1, data: e});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rvld) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvld", {31'h0, rvld}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("rdata", rdata, e.data);
          chk("rd_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : stim
    #12;
    chk("rst_rvld", {31'h0, rvld}, 32'h0);
    chk("rst_data", rdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;

    wr(SW, 32'h1000_0010, 32'hDEAD_BEEF);
    rd_exp(32'h1000_0010, 32'hDEAD_BEEF);

    wr(SW, 32'h1000_0010, 32'h1122_3344);
    wr(SB, 32'h1000_0011, 32'h0000_5A00);
    rd_exp(32'h1000_0010, 32'h1122_5A44);

    wr(SW, 32'h1000_0000, 32'hA5A5_0001);
    wr(SW, 32'h1000_0FFC, 32'hCAFE_F00D);
    idle();
    rd_exp(32'h1000_0000, 32'hA5A5_0001);
    rd_exp(32'h1000_0FFC, 32'hCAFE_F00D);
    idle();
    idle();

    issue(1'b1, 1'b0, SW, 32'h2000_0000, 32'h0);
    idle();
    chk("miss_err", {31'h0, err}, {31'h0, ERR});
    idle();
    chk("miss_err_sticky", {31'h0, err}, {31'h0, ERR});
    rd_exp(32'h1000_0FFC, 32'hCAFE_F00D);
    idle();
    chk("err_cleared", {31'h0, err}, 32'h0);

    wr(SH, 32'h1000_0003, 32'hBEEF_0000);
    idle();
    chk("misal_h_err", {31'h0, err}, {31'h0, ERR});
    rd_exp(32'h1000_0000, ERR ? 32'hA5A5_0001 : 32'hBEEF_0001);

    issue(1'b1, 1'b1, SW, 32'h1000_0010, 32'hFFFF_FFFF);
    idle();
    chk("rdwe_err", {31'h0, err}, {31'h0, ERR});
    wr(3'b011, 32'h1000_0010, 32'hFFFF_FFFF);
    wr(SW, 32'h3000_0010, 32'hFFFF_FFFF);
    rd_exp(32'h1000_0010, 32'h1122_5A44);

    wr(SH, 32'h1000_0012, 32'h1234_0000);
    wr(SB, 32'h1000_0FFF, 32'h7700_0000);
    rd_exp(32'h1000_0010, 32'h1234_5A44);
    rd_exp(32'h1000_0FFC, 32'h77FE_F00D);
    idle();

    issue(1'b1, 1'b0, SW, 32'h1000_0010, 32'h0);
    @(posedge clk);
    #1;
    rd    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_flush_rvld", {31'h0, rvld}, 32'h0);
    chk("rst_flush_data", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) idle();

    rd_exp(32'h1000_0010, 32'h1234_5A44);
    repeat (4) idle();
    chk("sb_empty", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
